// File: rtl/event_counter_bank.sv
// Bank of per-channel event counters with snapshot-and-clear into a valid/ready output register.
// Counters wrap or saturate at 2^WIDTH-1 and keep a sticky overflow flag per interval.
module event_counter_bank #(
    parameter int WIDTH    = 64,
    parameter int CHANNELS = 4,
    parameter int SATURATE = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       increment,
    input  logic                      trigger,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic [CHANNELS-1:0]       out_overflow,
    output logic                      out_dropped,
    output logic                      out_valid,
    input  logic                      out_ready
);

    // Handshake: the snapshot transfers on any edge where out_valid && out_ready.
    // A new trigger is accepted when the register is EMPTY or being drained that same edge.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t state, state_next;
    logic   accept;

    logic [WIDTH-1:0]          count_q [CHANNELS];
    logic [WIDTH-1:0]          count_d [CHANNELS];
    logic [CHANNELS-1:0]       ovf_q;
    logic [CHANNELS-1:0]       ovf_d;
    logic                      dropped_q;
    logic [CHANNELS*WIDTH-1:0] count_flat;

    always_comb begin
        state_next = state;
        accept     = trigger && ((state == EMPTY) || out_ready);
        case (state)
            EMPTY: if (accept) state_next = FULL;
            FULL:  if (out_ready && !trigger) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    assign out_valid = (state == FULL);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        logic at_max;
        logic wrap_evt;

        assign at_max   = (count_q[g] == {WIDTH{1'b1}});
        assign wrap_evt = increment[g] && at_max;

        // An increment on the capture edge starts the new interval at 1.
        always_comb begin
            count_d[g] = count_q[g];
            if (accept) begin
                count_d[g] = increment[g] ? WIDTH'(1) : '0;
            end else if (increment[g]) begin
                if (!at_max) begin
                    count_d[g] = count_q[g] + WIDTH'(1);
                end else if (SATURATE == 0) begin
                    count_d[g] = '0;
                end
            end
        end

        // An overflow on the capture edge is charged to the interval that begins there.
        assign ovf_d[g] = accept ? wrap_evt : (ovf_q[g] | wrap_evt);
    end

    always_comb begin
        count_flat = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            count_flat[i*WIDTH +: WIDTH] = count_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= EMPTY;
            ovf_q        <= '0;
            dropped_q    <= 1'b0;
            out_data     <= '0;
            out_overflow <= '0;
            out_dropped  <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                count_q[i] <= '0;
            end
        end else begin
            state <= state_next;
            ovf_q <= ovf_d;
            for (int i = 0; i < CHANNELS; i++) begin
                count_q[i] <= count_d[i];
            end
            if (accept) begin
                dropped_q    <= 1'b0;
                out_data     <= count_flat;
                out_overflow <= ovf_q;
                out_dropped  <= dropped_q;
            end else if (trigger) begin
                dropped_q <= 1'b1;
            end
        end
    end

endmodule
